// File: rtl/mealy_pattern_detector.sv
// mealy_pattern_detector
//   Runtime-programmable Mealy serial pattern detector. It holds a pattern of
//   1..PAT_W bits and a sliding history of recent input bits. match_o is
//   combinational and rises in the same cycle that the final pattern bit is
//   presented. The block also provides a saturating match counter and a
//   one-cycle error pulse when a configuration load is rejected.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   ena_i          block enable; when low, all state is frozen
//   bit_in_i       serial data bit
//   bit_valid_i    bit_in_i is valid in this cycle
//   cfg_load_i     load cfg_* in this cycle (the bit on the wire is dropped)
//   cfg_pattern_i  pattern; bit [len-1] arrives first, bit [0] arrives last
//   cfg_len_i      pattern length, legal range 1..PAT_W
//   cfg_overlap_i  1 = overlapping detection, 0 = non-overlapping
//   cnt_clr_i      synchronous clear of match_count_o
//   match_o        Mealy match output
//   match_count_o  saturating match count
//   cfg_err_o      one-cycle pulse when an illegal cfg_len is rejected
//   fill_o         number of valid history bits held (0..len-1)
module mealy_pattern_detector #(
  parameter int               PAT_W   = 8,
  parameter int               LEN_W   = $clog2(PAT_W + 1),
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 8'b0000_1011,
  parameter int               RST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_i,
  input  logic             bit_in_i,
  input  logic             bit_valid_i,
  input  logic             cfg_load_i,
  input  logic [PAT_W-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             cfg_overlap_i,
  input  logic             cnt_clr_i,
  output logic             match_o,
  output logic [CNT_W-1:0] match_count_o,
  output logic             cfg_err_o,
  output logic [LEN_W-1:0] fill_o
);

  localparam logic [LEN_W-1:0] PAT_W_L   = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] RST_LEN_L = LEN_W'(RST_LEN);

  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             accept;
  logic             cfg_ok;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len_m1;
  logic             match;

  assign accept = ena_i & bit_valid_i & ~cfg_load_i;
  assign cfg_ok = (cfg_len_i != '0) && (cfg_len_i <= PAT_W_L);
  assign window = {hist_q, bit_in_i};
  assign len_m1 = len_q - LEN_W'(1);

  // Only the low len bits take part in the compare; upper pattern bits are ignored.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign match = accept && (fill_q == len_m1) && (((window ^ pat_q) & mask) == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (ena_i) begin
      err_d = 1'b0;
      if (cfg_load_i) begin
        if (cfg_ok) begin
          pat_d  = cfg_pattern_i;
          len_d  = cfg_len_i;
          ovl_d  = cfg_overlap_i;
          hist_d = '0;
          fill_d = '0;
        end else begin
          err_d = 1'b1;
        end
      end else if (bit_valid_i) begin
        hist_d = window[PAT_W-2:0];
        // Non-overlap mode discards history so the next match needs len fresh bits.
        if (match && !ovl_q) begin
          fill_d = '0;
        end else if (fill_q != len_m1) begin
          fill_d = fill_q + LEN_W'(1);
        end
      end
      // Clear has priority over a coincident match.
      if (cnt_clr_i) begin
        cnt_d = '0;
      end else if (match && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= RST_PAT;
      len_q  <= RST_LEN_L;
      ovl_q  <= 1'b1;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // While in reset every input to match is gated by accept, but force it low explicitly.
  assign match_o       = match & rst_n;
  assign match_count_o = cnt_q;
  assign cfg_err_o     = err_q;
  assign fill_o        = fill_q;

endmodule
